// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared between the CPU's bit-serial load/store
// initiator and the serial memory responder that services it.
//   SERIAL_ADDR_W / SERIAL_DATA_W : default frame address / data widths
//   OP_READ / OP_WRITE            : op bit carried on the start cycle
//   serial_state_t                : responder FSM states
package cpu_pkg;

   localparam int unsigned SERIAL_ADDR_W = 4;
   localparam int unsigned SERIAL_DATA_W = 8;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_TURN,
      ST_RDATA
   } serial_state_t;

endpackage

// File: rtl/serial_mem_store.sv
// serial_mem_store: 2**ADDR_W x DATA_W flop-based word store.
// Ports:
//   clk, rst_n      : clock, async active-low reset (clears every word)
//   we, waddr, wdata: single synchronous write port
//   raddr, rdata    : combinational read port
module serial_mem_store #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/serial_mem_responder.sv
// serial_mem_responder: target end of the CPU's bit-serial load/store link.
// Frame (LSB first): start cycle carrying op, ADDR_W address bits, then
// either DATA_W write bits, or one turnaround cycle followed by DATA_W
// read bits driven on resp_bit.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req_start  : frame start strobe (only honoured in IDLE)
//   req_bit    : serial request bit (op, address, write data)
//   resp_bit   : serial read data, 0 when resp_valid is low
//   resp_valid : high while resp_bit carries read data
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse on the last cycle of a frame
//   parity_err : sticky write-parity error (SERIAL_MEM_PARITY_EN only)
// Optional feature macro: SERIAL_MEM_PARITY_EN adds an even-parity bit
// after the data on both write and read frames.
module serial_mem_responder
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = SERIAL_ADDR_W,
   parameter int unsigned DATA_W = SERIAL_DATA_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_start,
   input  logic req_bit,
   output logic resp_bit,
   output logic resp_valid,
   output logic busy,
   output logic done
`ifdef SERIAL_MEM_PARITY_EN
   ,
   output logic parity_err
`endif
);

   localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int unsigned CNT_W = $clog2(MAX_W + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
`ifdef SERIAL_MEM_PARITY_EN
   // Data phases run one extra cycle for the parity bit.
   localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W);
   localparam int unsigned      WSR_W     = DATA_W;
`else
   localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W - 1);
   // The last data bit is taken straight from req_bit at commit time,
   // so the write shifter only holds the first DATA_W-1 bits.
   localparam int unsigned      WSR_W     = DATA_W - 1;
`endif

   serial_state_t     state, state_d;
   logic [CNT_W-1:0]  cnt;
   logic              op;
   logic [ADDR_W-1:0] addr_sr;
   logic [WSR_W-1:0]  wdata_sr;
   logic [DATA_W-1:0] rdata_sr;

   logic              store_we;
   logic [DATA_W-1:0] store_wdata;
   logic [DATA_W-1:0] store_rdata;
   logic              data_end;

`ifdef SERIAL_MEM_PARITY_EN
   logic              rpar;
   logic              par_fail;
`endif

   assign data_end = (cnt == DATA_END);

   // State register and per-state bit counter (cleared on every entry).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         if ((state_d != state) || (state_d == ST_IDLE)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE: begin
            if (req_start) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (cnt == ADDR_LAST) begin
               case (op)
                  OP_WRITE: state_d = ST_WDATA;
                  OP_READ:  state_d = ST_TURN;
               endcase
            end
         end
         ST_WDATA: begin
            if (data_end) state_d = ST_IDLE;
         end
         ST_TURN: begin
            state_d = ST_RDATA;
         end
         ST_RDATA: begin
            if (data_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      busy       = (state != ST_IDLE);
      resp_valid = (state == ST_RDATA);
      done       = ((state == ST_WDATA) || (state == ST_RDATA)) && data_end;
      resp_bit   = 1'b0;
      if (state == ST_RDATA) begin
`ifdef SERIAL_MEM_PARITY_EN
         resp_bit = data_end ? rpar : rdata_sr[0];
`else
         resp_bit = rdata_sr[0];
`endif
      end
   end

   // Store write control: the commit happens on the frame's final edge.
   always_comb begin
`ifdef SERIAL_MEM_PARITY_EN
      par_fail    = (state == ST_WDATA) && data_end && (req_bit != ^wdata_sr);
      store_we    = (state == ST_WDATA) && data_end && !par_fail;
      store_wdata = wdata_sr;
`else
      store_we    = (state == ST_WDATA) && data_end;
      store_wdata = {req_bit, wdata_sr};
`endif
   end

   // Shift registers and op latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op       <= OP_READ;
         addr_sr  <= '0;
         wdata_sr <= '0;
         rdata_sr <= '0;
`ifdef SERIAL_MEM_PARITY_EN
         rpar     <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req_start) op <= req_bit;
            end
            ST_ADDR: begin
               addr_sr <= {req_bit, addr_sr[ADDR_W-1:1]};
            end
            ST_WDATA: begin
               wdata_sr <= {req_bit, wdata_sr[WSR_W-1:1]};
            end
            ST_TURN: begin
               rdata_sr <= store_rdata;
`ifdef SERIAL_MEM_PARITY_EN
               rpar     <= ^store_rdata;
`endif
            end
            ST_RDATA: begin
               rdata_sr <= rdata_sr >> 1;
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_MEM_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
      end else if (par_fail) begin
         parity_err <= 1'b1;
      end
   end
`endif

   serial_mem_store #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_store (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (store_we),
      .waddr (addr_sr),
      .wdata (store_wdata),
      .raddr (addr_sr),
      .rdata (store_rdata)
   );

endmodule

// File: tb/tb_serial_mem_responder.sv
module tb_serial_mem_responder;
   import cpu_pkg::*;

   localparam int AW = 4;
   localparam int DW = 8;
`ifdef SERIAL_MEM_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic req_start;
   logic req_bit;
   logic resp_bit;
   logic resp_valid;
   logic busy;
   logic done;
`ifdef SERIAL_MEM_PARITY_EN
   logic parity_err;
`endif

   serial_mem_responder #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_start  (req_start),
      .req_bit    (req_bit),
      .resp_bit   (resp_bit),
      .resp_valid (resp_valid),
      .busy       (busy),
      .done       (done)
`ifdef SERIAL_MEM_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          par;
   } exp_t;
   exp_t exp_q[$];

   // per-frame observations
   int fr_cyc, fr_done, fr_busy, fr_rv, fr_rv_first;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Response monitor: collects serial read words and checks them against
   // the scoreboard queue.
   logic [DW:0] mon_acc;
   int          mon_n = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_n = 0;
      end else if (resp_valid) begin
         mon_acc[mon_n] = resp_bit;
         mon_n++;
         if (mon_n == DW + PAR) begin
            mon_n = 0;
            if (exp_q.size() == 0) begin
               check("unexpected_response", 32'(mon_acc), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("read_data", 32'(mon_acc[DW-1:0]), 32'(e.data));
`ifdef SERIAL_MEM_PARITY_EN
               check("read_parity", 32'(mon_acc[DW]), 32'(e.par));
`endif
            end
         end
      end else begin
         check("resp_bit_idle", 32'(resp_bit), 32'd0);
      end
   end

   task automatic frame_begin();
      fr_cyc = 0; fr_done = 0; fr_busy = 0; fr_rv = 0; fr_rv_first = 0;
   endtask

   // One link cycle: drive after the rising edge, observe at the falling edge.
   task automatic step(input logic s, input logic b);
      @(posedge clk);
      #1;
      req_start = s;
      req_bit   = b;
      @(negedge clk);
      fr_cyc++;
      if (done && fr_done == 0) fr_done = fr_cyc;
      if (busy) fr_busy++;
      if (resp_valid) begin
         fr_rv++;
         if (fr_rv_first == 0) fr_rv_first = fr_cyc;
      end
   endtask

   // bits holds data (and parity at index DW), nbits of them are sent
   task automatic write_core(input logic [AW-1:0] a, input logic [DW:0] bits, input int nbits);
      frame_begin();
      step(1'b1, OP_WRITE);
      for (int k = 0; k < AW; k++) step(1'b0, a[k]);
      for (int k = 0; k < nbits; k++) step(1'b0, bits[k]);
      check("write_done_cycle", 32'(fr_done), 32'(1 + AW + DW + PAR));
      check("write_busy_cycles", 32'(fr_busy), 32'(AW + DW + PAR));
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      write_core(a, {^d, d}, DW + PAR);
   endtask

   // glitch: address-bit index on which req_start is also pulsed (-1 = none)
   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int glitch);
      exp_t e;
      e.data = d;
      e.par  = ^d;
      exp_q.push_back(e);
      frame_begin();
      step(1'b1, OP_READ);
      for (int k = 0; k < AW; k++) step(k == glitch, a[k]);
      for (int k = 0; k < 1 + DW + PAR; k++) step(1'b0, 1'($urandom_range(0, 1)));
      check("read_done_cycle", 32'(fr_done), 32'(2 + AW + DW + PAR));
      check("read_valid_first", 32'(fr_rv_first), 32'(AW + 3));
      check("read_valid_cycles", 32'(fr_rv), 32'(DW + PAR));
      check("read_busy_cycles", 32'(fr_busy), 32'(1 + AW + DW + PAR));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_start = 1'b0;
      req_bit   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 32'({busy, resp_valid, done, resp_bit}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Abort a write to 0x5 mid-frame with a 3-cycle reset.
      frame_begin();
      step(1'b1, OP_WRITE);
      for (int k = 0; k < AW; k++) step(1'b0, (k == 0 || k == 2));
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      req_start = 1'b0;
      req_bit   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midframe_reset_outputs", 32'({busy, resp_valid, done, resp_bit}), 32'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      do_read(4'h5, 8'h00, -1);

      // Write then read.
      do_write(4'h3, 8'hA5);
      do_read(4'h3, 8'hA5, -1);

      // Back-to-back: read starts on the cycle right after the write's done.
      do_write(4'hF, 8'h3C);
      do_read(4'hF, 8'h3C, -1);

      // Start strobe while busy is ignored.
      do_write(4'h2, 8'h11);
      do_read(4'h2, 8'h11, 1);
      frame_begin();
      step(1'b0, 1'b0);
      check("busy_after_glitch_read", 32'(busy), 32'd0);

      // Address isolation.
      do_write(4'h0, 8'hFF);
      do_write(4'hF, 8'h01);
      do_read(4'h0, 8'hFF, -1);
      do_read(4'hF, 8'h01, -1);
      do_read(4'h8, 8'h00, -1);

`ifdef SERIAL_MEM_PARITY_EN
      do_write(4'h1, 8'h01);
      check("parity_err_clean", 32'(parity_err), 32'd0);
      write_core(4'h1, 9'h007, DW + 1);
      check("parity_err_set", 32'(parity_err), 32'd1);
      do_read(4'h1, 8'h01, -1);
      check("parity_err_sticky", 32'(parity_err), 32'd1);
`endif

      repeat (3) step(1'b0, 1'b0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
